// File: rtl/counter_pkg.sv
// Shared encodings and sizing helpers for the modulo counter family.
package counter_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    localparam bit MODE_WRAP = 1'b0;
    localparam bit MODE_SAT  = 1'b1;

    // Ceiling log2; returns 0 for values <= 1, callers apply their own minimum width.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Divides the enable stream by PRESCALE; tick marks the last en-cycle of each phase.
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sync_clr,
    output logic tick
);

    localparam int PW = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
    localparam logic [PW-1:0] PHASE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc;

    // With PRESCALE=1 the phase register stays at 0, so tick reduces to en.
    assign tick = en && (presc == PHASE_LAST);

    always_ff @(posedge clk) begin
        if (rst || sync_clr) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else if (en) begin
            presc <= presc + PW'(1);
        end
    end

endmodule

// File: rtl/counter_mod.sv
// Modulo-MOD up/down counter with prescaler, load, clear, wrap/saturate mode,
// a registered terminal-count pulse and a sticky overflow flag.
module counter_mod
    import counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MOD      = 10,
    parameter int PRESCALE = 1,
    parameter bit SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             dout,
    output logic             ovf
);

    generate
        if (MOD < 2) begin : g_bad_mod_low
            $error("counter_mod: MOD must be at least 2");
        end
        if ((WIDTH < 31) && (MOD > (1 << WIDTH))) begin : g_bad_mod_high
            $error("counter_mod: MOD must not exceed 2**WIDTH");
        end
        if (PRESCALE < 1) begin : g_bad_presc
            $error("counter_mod: PRESCALE must be at least 1");
        end
    endgenerate

    localparam logic [WIDTH-1:0] TERM_HI = WIDTH'(MOD - 1);

    logic             tick;
    logic             at_term;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] cnt_next_tick;

    counter_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .sync_clr(clear | load),
        .tick    (tick)
    );

    assign load_clamped = (load_val > TERM_HI) ? TERM_HI : load_val;
    assign at_term      = (up == DIR_UP) ? (cnt == TERM_HI) : (cnt == '0);

    always_comb begin
        cnt_next_tick = cnt;
        if (at_term) begin
            if (SATURATE == MODE_WRAP) begin
                cnt_next_tick = (up == DIR_UP) ? '0 : TERM_HI;
            end
        end else if (up == DIR_UP) begin
            cnt_next_tick = cnt + WIDTH'(1);
        end else begin
            cnt_next_tick = cnt - WIDTH'(1);
        end
    end

    // Priority: rst > clear > load > tick; dout is a one-cycle pulse per terminal event.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt  <= '0;
            dout <= 1'b0;
            ovf  <= 1'b0;
        end else if (load) begin
            cnt  <= load_clamped;
            dout <= 1'b0;
        end else if (tick) begin
            cnt  <= cnt_next_tick;
            dout <= at_term;
            if (at_term) begin
                ovf <= 1'b1;
            end
        end else begin
            dout <= 1'b0;
        end
    end

endmodule

// File: tb/tb_counter_mod.sv
// Directed bench for counter_mod: wrap, saturate and prescaled instances share one stimulus.
module tb_counter_mod;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, up, clear, load;
    logic [3:0] load_val;

    logic [3:0] cnt_w, cnt_s, cnt_p;
    logic       dout_w, dout_s, dout_p;
    logic       ovf_w, ovf_s, ovf_p;

    counter_mod #(.WIDTH(4), .MOD(10), .PRESCALE(1), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .up(up), .clear(clear), .load(load),
        .load_val(load_val), .cnt(cnt_w), .dout(dout_w), .ovf(ovf_w)
    );

    counter_mod #(.WIDTH(4), .MOD(10), .PRESCALE(1), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .en(en), .up(up), .clear(clear), .load(load),
        .load_val(load_val), .cnt(cnt_s), .dout(dout_s), .ovf(ovf_s)
    );

    counter_mod #(.WIDTH(4), .MOD(10), .PRESCALE(3), .SATURATE(1'b0)) u_presc (
        .clk(clk), .rst(rst), .en(en), .up(up), .clear(clear), .load(load),
        .load_val(load_val), .cnt(cnt_p), .dout(dout_p), .ovf(ovf_p)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      name;
        logic       rst, en, up, clear, load;
        logic [3:0] load_val;
        logic [3:0] exp_cnt;
        logic       exp_dout, exp_ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(string n, bit r, bit e, bit u, bit c, bit l,
                                    int v, int ec, bit ed, bit eo);
        vec_t x;
        x.name = n; x.rst = r; x.en = e; x.up = u; x.clear = c; x.load = l;
        x.load_val = 4'(v); x.exp_cnt = 4'(ec); x.exp_dout = ed; x.exp_ovf = eo;
        vecs.push_back(x);
    endfunction

    task automatic drive(bit r, bit e, bit u, bit c, bit l, int v);
        rst = r; en = e; up = u; clear = c; load = l; load_val = 4'(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, int idx, logic [3:0] act, logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    initial begin
        drive(1, 0, 1, 0, 0, 0);

        // Test 1: reset, then count up through a wrap.
        add_vec("reset1", 1, 0, 1, 0, 0, 0, 0, 0, 0);
        add_vec("reset2", 1, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 12; k++)
            add_vec("up", 0, 1, 1, 0, 0, 0, k % 10, k == 10, k >= 10);
        // Test 2: from 0 count down, wrap 0 -> 9 pulses dout once.
        add_vec("reset3", 1, 0, 1, 0, 0, 0, 0, 0, 0);
        add_vec("down9", 0, 1, 0, 0, 0, 0, 9, 1, 1);
        add_vec("down8", 0, 1, 0, 0, 0, 0, 8, 0, 1);
        add_vec("down7", 0, 1, 0, 0, 0, 0, 7, 0, 1);
        // Test 5: load, clamped load, clear beats load.
        add_vec("load7", 0, 1, 1, 0, 1, 7, 7, 0, 1);
        add_vec("load12", 0, 1, 1, 0, 1, 12, 9, 0, 1);
        add_vec("wrap_after_load", 0, 1, 1, 0, 0, 0, 0, 1, 1);
        add_vec("clear_load", 0, 1, 1, 1, 1, 5, 0, 0, 0);
        add_vec("idle", 0, 0, 1, 0, 0, 0, 0, 0, 0);
        // Test 6: reach cnt=5 with ovf set, then reset mid-count.
        add_vec("load9", 0, 0, 1, 0, 1, 9, 9, 0, 0);
        add_vec("to0", 0, 1, 1, 0, 0, 0, 0, 1, 1);
        for (int k = 1; k <= 5; k++)
            add_vec("to5", 0, 1, 1, 0, 0, 0, k, 0, 1);
        add_vec("rst_mid", 1, 1, 1, 0, 0, 0, 0, 0, 0);
        add_vec("restart", 0, 1, 1, 0, 0, 0, 1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].up, vecs[i].clear,
                  vecs[i].load, int'(vecs[i].load_val));
            step();
            chk({vecs[i].name, ".cnt"},  i, cnt_w, vecs[i].exp_cnt);
            chk({vecs[i].name, ".dout"}, i, {3'b0, dout_w}, {3'b0, vecs[i].exp_dout});
            chk({vecs[i].name, ".ovf"},  i, {3'b0, ovf_w}, {3'b0, vecs[i].exp_ovf});
        end

        // Test 3: saturating instance holds at 9 with dout held high.
        drive(1, 0, 1, 0, 0, 0);
        step();
        chk("sat_reset.cnt", 0, cnt_s, 4'd0);
        for (int k = 1; k <= 12; k++) begin
            drive(0, 1, 1, 0, 0, 0);
            step();
            chk("sat.cnt",  k, cnt_s, 4'((k > 9) ? 9 : k));
            chk("sat.dout", k, {3'b0, dout_s}, {3'b0, 1'(k >= 10)});
            chk("sat.ovf",  k, {3'b0, ovf_s},  {3'b0, 1'(k >= 10)});
        end
        drive(0, 0, 1, 0, 0, 0);
        step();
        chk("sat_hold.cnt",  0, cnt_s, 4'd9);
        chk("sat_hold.dout", 0, {3'b0, dout_s}, 4'd0);
        chk("sat_hold.ovf",  0, {3'b0, ovf_s},  4'd1);

        // Test 4: prescale by 3, then freeze mid-phase and resume without slip.
        drive(1, 0, 1, 0, 0, 0);
        step();
        chk("presc_reset.cnt", 0, cnt_p, 4'd0);
        for (int k = 1; k <= 10; k++) begin
            drive(0, 1, 1, 0, 0, 0);
            step();
            chk("presc.cnt", k, cnt_p, 4'(k / 3));
        end
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 1, 0, 0, 0);
            step();
            chk("presc_frozen.cnt", k, cnt_p, 4'd3);
        end
        drive(0, 1, 1, 0, 0, 0);
        step();
        chk("presc_resume1.cnt", 0, cnt_p, 4'd3);
        step();
        chk("presc_resume2.cnt", 0, cnt_p, 4'd4);
        // Load mid-phase restarts the prescaler: next tick is three en-cycles later.
        step();
        drive(0, 1, 1, 0, 1, 7);
        step();
        chk("presc_load.cnt", 0, cnt_p, 4'd7);
        for (int k = 1; k <= 3; k++) begin
            drive(0, 1, 1, 0, 0, 0);
            step();
            chk("presc_after_load.cnt", k, cnt_p, 4'((k == 3) ? 8 : 7));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
